// File: rtl/efuse_pkg.sv
// rtl/efuse_pkg.sv - shared FSM state type, register map constants and width helper for the eFuse controller
package efuse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SENSE,
        ST_SCAN,
        ST_SETUP,
        ST_PULSE,
        ST_GAP,
        ST_ACK
    } state_t;

    localparam int CTRL_WORD          = 0;
    localparam int STATUS_WORD        = 1;
    localparam int CTRL_LOCK_BIT      = 0;
    localparam int STAT_BUSY_BIT      = 0;
    localparam int STAT_ERR_LOCK_BIT  = 1;
    localparam int STAT_ERR_ZERO_BIT  = 2;

    // A one-bit word still needs a one-bit select port.
    function automatic int sel_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/efuse_wb_ctrl_if.sv
// rtl/efuse_wb_ctrl_if.sv - Wishbone slave bus bundle for the eFuse controller
interface efuse_wb_ctrl_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/efuse_pulse_timer.sv
// rtl/efuse_pulse_timer.sv - loadable saturating down-counter timing sense and program pulses
module efuse_pulse_timer #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done
);
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // done marks the final cycle of the loaded interval
    assign done = (cnt == CW'(1));
endmodule

// File: rtl/efuse_wb_ctrl.sv
// rtl/efuse_wb_ctrl.sv - Wishbone eFuse controller with serial bit programming; EFUSE_SHADOW_EN adds a swept read shadow
module efuse_wb_ctrl
    import efuse_pkg::*;
#(
    parameter int DEPTH        = 64,
    parameter int WIDTH        = 8,
    parameter int PGM_CYCLES   = 200,
    parameter int SENSE_CYCLES = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int BW = sel_width(WIDTH)
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    efuse_wb_ctrl_if.slave   wb,
    output logic [AW-1:0]    fuse_addr_o,
    output logic [BW-1:0]    fuse_bit_o,
    output logic             fuse_pgm_o,
    output logic             fuse_sense_o,
    input  logic [WIDTH-1:0] fuse_q_i,
    output logic             busy_o
);
    localparam int TMAX = (PGM_CYCLES > SENSE_CYCLES) ? PGM_CYCLES : SENSE_CYCLES;
    localparam int CW   = $clog2(TMAX + 1);

    state_t           state, state_nx;
    logic             req, ctl_sel, zero_wr, tmr_load, tmr_done, unused_bits;
    logic [AW-1:0]    word, sweep_idx;
    logic [CW-1:0]    tmr_val;
    logic [WIDTH-1:0] wdata_q, mask_q, pmask_q, shadow_rd;
    logic [31:0]      rdata_q, status_w;
    logic             wr_q, lock_q, err_lock_q, err_zero_q, sweep_q;

    function automatic logic [BW-1:0] lowest_bit(input logic [WIDTH-1:0] m);
        lowest_bit = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (m[i]) lowest_bit = BW'(i);
        end
    endfunction

    assign req         = wb.wb_cyc_i & wb.wb_stb_i;
    assign ctl_sel     = wb.wb_adr_i[AW+2];
    assign word        = wb.wb_adr_i[AW+1:2];
    assign zero_wr     = (wb.wb_sel_i == 4'd0) || (wb.wb_dat_i[WIDTH-1:0] == '0);
    assign unused_bits = ^{wb.wb_adr_i, wb.wb_dat_i, wb.wb_sel_i};

    always_comb begin
        status_w                    = '0;
        status_w[STAT_BUSY_BIT]     = busy_o;
        status_w[STAT_ERR_LOCK_BIT] = err_lock_q;
        status_w[STAT_ERR_ZERO_BIT] = err_zero_q;
    end

`ifdef EFUSE_SHADOW_EN
    localparam bit SHADOW = 1'b1;
    logic [WIDTH-1:0] shadow_q [DEPTH];

    assign shadow_rd = shadow_q[word];

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sweep_q   <= 1'b1;
            sweep_idx <= '0;
            for (int i = 0; i < DEPTH; i++) shadow_q[i] <= '0;
        end else if (state == ST_SENSE && tmr_done && sweep_q) begin
            shadow_q[fuse_addr_o] <= fuse_q_i;
            sweep_idx             <= sweep_idx + 1'b1;
            if (sweep_idx == AW'(DEPTH - 1)) sweep_q <= 1'b0;
        end else if (state == ST_SCAN && wr_q && mask_q == '0) begin
            shadow_q[fuse_addr_o] <= shadow_q[fuse_addr_o] | pmask_q;
        end
    end
`else
    localparam bit SHADOW = 1'b0;
    assign shadow_rd = '0;
    assign sweep_q   = 1'b0;
    assign sweep_idx = '0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state <= ST_IDLE;
        else            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        tmr_load = 1'b0;
        tmr_val  = CW'(SENSE_CYCLES);
        case (state)
            ST_IDLE: begin
                if (sweep_q) begin
                    state_nx = ST_SENSE;
                    tmr_load = 1'b1;
                end else if (req) begin
                    if (ctl_sel || (wb.wb_we_i && (zero_wr || lock_q)) || (!wb.wb_we_i && SHADOW)) begin
                        state_nx = ST_ACK;
                    end else begin
                        state_nx = ST_SENSE;
                        tmr_load = 1'b1;
                    end
                end
            end
            ST_SENSE: if (tmr_done) state_nx = wr_q ? ST_SCAN : (sweep_q ? ST_IDLE : ST_ACK);
            ST_SCAN:  state_nx = (mask_q == '0) ? ST_ACK : ST_SETUP;
            ST_SETUP: begin
                state_nx = ST_PULSE;
                tmr_load = 1'b1;
                tmr_val  = CW'(PGM_CYCLES);
            end
            ST_PULSE: if (tmr_done) state_nx = ST_GAP;
            ST_GAP:   state_nx = ST_SCAN;
            ST_ACK:   state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            fuse_addr_o <= '0;
            fuse_bit_o  <= '0;
            wdata_q     <= '0;
            mask_q      <= '0;
            pmask_q     <= '0;
            rdata_q     <= '0;
            wr_q        <= 1'b0;
            lock_q      <= 1'b0;
            err_lock_q  <= 1'b0;
            err_zero_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sweep_q) begin
                        fuse_addr_o <= sweep_idx;
                        wr_q        <= 1'b0;
                    end else if (req) begin
                        wr_q    <= wb.wb_we_i;
                        wdata_q <= wb.wb_dat_i[WIDTH-1:0];
                        rdata_q <= '0;
                        if (ctl_sel) begin
                            if (word == AW'(CTRL_WORD)) begin
                                rdata_q[CTRL_LOCK_BIT] <= lock_q;
                                if (wb.wb_we_i && wb.wb_sel_i[0] && wb.wb_dat_i[CTRL_LOCK_BIT]) lock_q <= 1'b1;
                            end else if (word == AW'(STATUS_WORD)) begin
                                rdata_q <= status_w;
                                if (wb.wb_we_i && wb.wb_sel_i[0]) begin
                                    if (wb.wb_dat_i[STAT_ERR_LOCK_BIT]) err_lock_q <= 1'b0;
                                    if (wb.wb_dat_i[STAT_ERR_ZERO_BIT]) err_zero_q <= 1'b0;
                                end
                            end
                        end else if (wb.wb_we_i) begin
                            if (zero_wr)     err_zero_q  <= 1'b1;
                            else if (lock_q) err_lock_q  <= 1'b1;
                            else             fuse_addr_o <= word;
                        end else if (SHADOW) begin
                            rdata_q <= 32'(shadow_rd);
                        end else begin
                            fuse_addr_o <= word;
                        end
                    end
                end
                ST_SENSE: begin
                    if (tmr_done) begin
                        // only bits not yet blown are worth a pulse
                        if (wr_q) begin
                            mask_q  <= wdata_q & ~fuse_q_i;
                            pmask_q <= wdata_q & ~fuse_q_i;
                        end else begin
                            rdata_q <= 32'(fuse_q_i);
                        end
                    end
                end
                ST_SCAN: begin
                    if (mask_q != '0) begin
                        fuse_bit_o <= lowest_bit(mask_q);
                        mask_q     <= mask_q & (mask_q - 1'b1);
                    end
                end
                default: ;
            endcase
        end
    end

    efuse_pulse_timer #(.CW(CW)) u_timer (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_ni),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    assign fuse_sense_o = (state == ST_SENSE);
    assign fuse_pgm_o   = (state == ST_PULSE);
    assign busy_o       = (state != ST_IDLE) || sweep_q;
    // an abandoned cycle still finishes programming but never sees its ack
    assign wb.wb_ack_o  = (state == ST_ACK) && wb.wb_cyc_i;
    assign wb.wb_dat_o  = (wb.wb_ack_o && !wr_q) ? rdata_q : '0;
endmodule

// File: tb/tb_efuse_wb_ctrl.sv
// tb/tb_efuse_wb_ctrl.sv - self-checking bench for efuse_wb_ctrl with an eFuse array model and ack scoreboard
`timescale 1ns/1ps
module tb_efuse_wb_ctrl;
    localparam int DEPTH = 64, WIDTH = 8, PGM = 200, SC = 4, AW = 6, BW = 3;
`ifdef EFUSE_SHADOW_EN
    localparam int   RLAT     = 1;
    localparam logic RST_BUSY = 1'b1;
`else
    localparam int   RLAT     = SC + 1;
    localparam logic RST_BUSY = 1'b0;
`endif
    // accept cycle, sense window, first scan; each pulsed bit adds setup+pulse+gap+scan
    localparam int WLAT0 = 2 + SC;
    localparam int WLAT1 = WLAT0 + (PGM + 3);
    localparam int WLAT2 = WLAT0 + 2 * (PGM + 3);
    localparam logic [31:0] CTRL = 32'h100, STAT = 32'h104;

    typedef struct {
        logic             we;
        logic [31:0]      adr;
        logic [3:0]       sel;
        logic [31:0]      dat;
        logic [31:0]      exp_rd;
        int               exp_lat;
        logic [WIDTH-1:0] exp_bits;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [AW-1:0]    fuse_addr;
    logic [BW-1:0]    fuse_bit;
    logic             fuse_pgm, fuse_sense, busy;
    logic [WIDTH-1:0] fuse_q;
    logic [WIDTH-1:0] fuse_mem [DEPTH];

    int n_vec = 0, n_err = 0;
    logic [31:0] exp_q [$];
    int pw_q [$], pb_q [$], gap_q [$];
    int run = 0, low = 0, cur_bit = 0;

    efuse_wb_ctrl_if bus ();

    efuse_wb_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .PGM_CYCLES(PGM), .SENSE_CYCLES(SC)) dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (rst_n),
        .wb           (bus),
        .fuse_addr_o  (fuse_addr),
        .fuse_bit_o   (fuse_bit),
        .fuse_pgm_o   (fuse_pgm),
        .fuse_sense_o (fuse_sense),
        .fuse_q_i     (fuse_q),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;
    assign fuse_q = fuse_mem[fuse_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // fuse model: a bit blows when a pulse completes; pulse widths, bits and gaps are logged
    always @(negedge clk) begin
        if (!rst_n) begin
            run = 0;
        end else if (fuse_pgm) begin
            if (run == 0 && pw_q.size() > 0) gap_q.push_back(low);
            run++;
            cur_bit = int'(fuse_bit);
        end else begin
            if (run > 0) begin
                pw_q.push_back(run);
                pb_q.push_back(cur_bit);
                fuse_mem[fuse_addr][cur_bit] = 1'b1;
                run = 0;
                low = 0;
            end
            low++;
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus.wb_ack_o) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_ack: got ack with dat %0h expected no ack", bus.wb_dat_o);
            end else begin
                chk("ack_data", bus.wb_dat_o, exp_q.pop_front());
            end
        end
    end

    task automatic drive(input logic we, input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_sel_i = sel;
        bus.wb_dat_i = dat;
    endtask

    task automatic idle_bus();
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    task automatic wait_ack(input string name, output int lat);
        lat = 0;
        forever begin
            @(negedge clk);
            if (bus.wb_ack_o) break;
            lat++;
            if (lat > 5000) begin
                n_vec++;
                n_err++;
                $display("FAIL %s_timeout: got no ack expected ack within 5000 cycles", name);
                break;
            end
        end
    endtask

    task automatic xfer(input vec_t v, input string name);
        int lat;
        exp_q.push_back(v.we ? 32'h0 : v.exp_rd);
        @(posedge clk); #1;
        drive(v.we, v.adr, v.sel, v.dat);
        wait_ack(name, lat);
        if (v.exp_lat >= 0) chk({name, "_lat"}, lat, v.exp_lat);
        @(posedge clk); #1;
        idle_bus();
    endtask

    task automatic clear_log();
        pw_q.delete();
        pb_q.delete();
        gap_q.delete();
    endtask

    task automatic check_pulses(input logic [WIDTH-1:0] exp_bits, input string name);
        logic [WIDTH-1:0] got;
        int prev;
        got  = '0;
        prev = -1;
        chk({name, "_pulse_count"}, pw_q.size(), $countones(exp_bits));
        foreach (pw_q[k]) begin
            chk({name, "_pulse_width"}, pw_q[k], PGM);
            chk({name, "_pulse_order"}, 32'(pb_q[k] > prev), 32'd1);
            prev = pb_q[k];
            got[pb_q[k]] = 1'b1;
        end
        foreach (gap_q[k]) chk({name, "_pulse_gap"}, gap_q[k], 3);
        chk({name, "_pulse_bits"}, 32'(got), 32'(exp_bits));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_bus();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t vt [$];

    initial begin
        int n;
        vec_t rv;
        foreach (fuse_mem[i]) fuse_mem[i] = '0;
        idle_bus();
        bus.wb_adr_i = '0;
        bus.wb_sel_i = '0;
        bus.wb_dat_i = '0;

        //               we    adr    sel    dat       exp_rd  lat    bits
        vt.push_back('{1'b0, STAT,  4'hf, 32'h0,   32'h0,  1,     8'h00});
        vt.push_back('{1'b0, CTRL,  4'hf, 32'h0,   32'h0,  1,     8'h00});
        vt.push_back('{1'b1, 32'h14, 4'hf, 32'h81, 32'h0,  WLAT2, 8'h81});
        vt.push_back('{1'b0, 32'h14, 4'hf, 32'h0,  32'h81, RLAT,  8'h00});
        vt.push_back('{1'b1, 32'h14, 4'hf, 32'h83, 32'h0,  WLAT1, 8'h02});
        vt.push_back('{1'b0, 32'h14, 4'hf, 32'h0,  32'h83, RLAT,  8'h00});
        vt.push_back('{1'b1, 32'h14, 4'hf, 32'h03, 32'h0,  WLAT0, 8'h00});
        vt.push_back('{1'b1, 32'h1C, 4'h0, 32'h01, 32'h0,  1,     8'h00});
        vt.push_back('{1'b0, STAT,  4'hf, 32'h0,   32'h4,  1,     8'h00});
        vt.push_back('{1'b1, STAT,  4'hf, 32'h4,   32'h0,  1,     8'h00});
        vt.push_back('{1'b0, STAT,  4'hf, 32'h0,   32'h0,  1,     8'h00});
        vt.push_back('{1'b1, 32'hFC, 4'hf, 32'h100, 32'h0, 1,     8'h00});
        vt.push_back('{1'b0, STAT,  4'hf, 32'h0,   32'h4,  1,     8'h00});
        vt.push_back('{1'b1, STAT,  4'hf, 32'h4,   32'h0,  1,     8'h00});
        vt.push_back('{1'b1, CTRL,  4'hf, 32'h1,   32'h0,  1,     8'h00});
        vt.push_back('{1'b0, CTRL,  4'hf, 32'h0,   32'h1,  1,     8'h00});
        vt.push_back('{1'b1, 32'h18, 4'hf, 32'hFF, 32'h0,  1,     8'h00});
        vt.push_back('{1'b0, STAT,  4'hf, 32'h0,   32'h2,  1,     8'h00});
        vt.push_back('{1'b1, STAT,  4'hf, 32'h2,   32'h0,  1,     8'h00});
        vt.push_back('{1'b0, STAT,  4'hf, 32'h0,   32'h0,  1,     8'h00});
        vt.push_back('{1'b0, 32'h10C, 4'hf, 32'h0, 32'h0,  1,     8'h00});
        vt.push_back('{1'b0, 32'h18, 4'hf, 32'h0,  32'h0,  RLAT,  8'h00});
        vt.push_back('{1'b1, CTRL,  4'hf, 32'h0,   32'h0,  1,     8'h00});
        vt.push_back('{1'b0, CTRL,  4'hf, 32'h0,   32'h1,  1,     8'h00});

        do_reset();
        #1;
        chk("reset_fuse_outputs", {28'h0, fuse_pgm, fuse_sense, bus.wb_ack_o, |{fuse_addr, fuse_bit}}, 32'h0);
        chk("reset_dat_o", bus.wb_dat_o, 32'h0);
        chk("reset_busy", 32'(busy), 32'(RST_BUSY));

        for (int i = 0; i < vt.size(); i++) begin
            clear_log();
            xfer(vt[i], $sformatf("vec%0d", i));
            check_pulses(vt[i].exp_bits, $sformatf("vec%0d", i));
        end

        // reset 50 cycles into a program pulse
        do_reset();
        clear_log();
        @(posedge clk); #1;
        drive(1'b1, 32'h24, 4'hf, 32'h01);
        n = 0;
        while (!fuse_pgm && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("midpulse_started", 32'(fuse_pgm), 32'd1);
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midpulse_pgm_drop", 32'(fuse_pgm), 32'd0);
        chk("midpulse_busy", 32'(busy), 32'(RST_BUSY));
        idle_bus();
        @(negedge clk);
        rst_n = 1'b1;
        chk("midpulse_no_logged_pulse", pw_q.size(), 0);
        rv = '{1'b0, 32'h24, 4'hf, 32'h0, 32'h0, RLAT, 8'h00};
        xfer(rv, "after_reset_rd9");
        rv = '{1'b0, 32'h14, 4'hf, 32'h0, 32'h83, RLAT, 8'h00};
        xfer(rv, "after_reset_rd5");

        // write in flight, then an immediate read of the last word on the same cycle
        clear_log();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        @(posedge clk); #1;
        drive(1'b1, 32'h28, 4'hf, 32'h01);
        wait_ack("b2b_wr", n);
        chk("b2b_wr_lat", n, WLAT1);
        @(posedge clk); #1;
        drive(1'b0, 32'(DEPTH - 1) << 2, 4'hf, 32'h0);
        wait_ack("b2b_rd", n);
        chk("b2b_rd_lat", n, RLAT);
        @(posedge clk); #1;
        idle_bus();
        check_pulses(8'h01, "b2b");

        // cycle dropped mid-program: pulse completes, no ack
        clear_log();
        @(posedge clk); #1;
        drive(1'b1, 32'h2C, 4'hf, 32'h01);
        repeat (20) @(negedge clk);
        idle_bus();
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("cycdrop_idle", 32'(busy), 32'd0);
        check_pulses(8'h01, "cycdrop");
        rv = '{1'b0, 32'h2C, 4'hf, 32'h0, 32'h01, RLAT, 8'h00};
        xfer(rv, "cycdrop_rd11");
        rv = '{1'b0, 32'h28, 4'hf, 32'h0, 32'h01, RLAT, 8'h00};
        xfer(rv, "b2b_rd10");

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
